// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX round-robin arbiter: state encoding,
// header prefix byte and default byte width.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;
  localparam logic [7:0]  HDR_PREFIX    = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N_SRC requesters, the arbiter and the UART TX input.
// master = arbiter side, slave = requesters plus UART side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
);

  logic [N_SRC*DATA_BITS-1:0] s_axis_tdata;
  logic [N_SRC-1:0]           s_axis_tvalid;
  logic [N_SRC-1:0]           s_axis_tlast;
  logic [N_SRC-1:0]           s_axis_tready;
  logic [DATA_BITS-1:0]       m_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin finder: first set request at or after ptr (mod N).
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_sh;
  logic [IW-1:0]  pos;
  logic [IW:0]    sum;

  // Rotating right by ptr puts request (ptr+j) mod N at bit j.
  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[N-1:0];
    rot_sh = '0;
    pos    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      rot_sh = rot >> i;
      if (!found && rot_sh[0]) begin
        pos   = IW'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among N_SRC requesters.
// Define UART_ARB_ID_HDR_EN to prefix each grant with header byte 0xA0|grant_id.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  uart_tx_arbiter_if.master        bus,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(N_SRC);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;

  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic                 stage_free;
  logic                 g_valid, g_last;
  logic [DATA_BITS-1:0] g_data;
  logic                 burst_end;

  rr_picker #(
    .N  (N_SRC),
    .IW (IW)
  ) u_rr_picker (
    .req   (bus.s_axis_tvalid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign stage_free = !tvalid_q || bus.m_axis_tready;
  assign g_valid    = bus.s_axis_tvalid[grant_q];
  assign g_last     = bus.s_axis_tlast[grant_q];
  assign g_data     = bus.s_axis_tdata[grant_q*DATA_BITS +: DATA_BITS];
  assign burst_end  = ({1'b0, cnt_q} + 9'd1) == 9'(MAX_BURST);

  assign bus.s_axis_tready = (state_q == ST_XFER && stage_free) ? (N_SRC'(1) << grant_q) : '0;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != ST_IDLE) || tvalid_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q && !bus.m_axis_tready;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
`ifdef UART_ARB_ID_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      ST_HDR: begin
        if (stage_free) begin
          tdata_d  = DATA_BITS'(HDR_PREFIX) | DATA_BITS'(grant_q);
          tvalid_d = 1'b1;
          state_d  = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        // A stalled source keeps the grant; only tlast or the burst limit releases it.
        if (g_valid && stage_free) begin
          tdata_d  = g_data;
          tvalid_d = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          if (g_last || burst_end) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == IW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_SRC=4, MAX_BURST=4): directed
// sequences, an arbitration-order table and randomized traffic against a stream model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
`ifdef UART_ARB_ID_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_en = 1'b1;
  logic [1:0] grant_id;
  logic       busy;

  uart_tx_arbiter_if #(.N_SRC(N), .DATA_BITS(8)) bus ();

  uart_tx_arbiter #(.N_SRC(N), .DATA_BITS(8), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (arb_en),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] n;
    logic [7:0] ord;
  } arb_vec_t;

  beat_t      src_q[N][$];
  logic [7:0] obs[$];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         tr_mode = 0;
  int         m_ptr = 0;
  logic [N-1:0] pend_s = '0;
  logic       pend_m = 1'b0;
  logic [7:0] pend_data = '0;
  logic       hold = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        bus.s_axis_tvalid[i]        = 1'b1;
        bus.s_axis_tdata[i*8 +: 8]  = src_q[i][0].data;
        bus.s_axis_tlast[i]         = src_q[i][0].last;
      end else begin
        bus.s_axis_tvalid[i]        = 1'b0;
        bus.s_axis_tdata[i*8 +: 8]  = 8'h00;
        bus.s_axis_tlast[i]         = 1'b0;
      end
    end
  endtask

  task automatic drive_rdy();
    case (tr_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
      default: bus.m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
    endcase
  endtask

  task automatic calc_hs();
    pend_s    = bus.s_axis_tvalid & bus.s_axis_tready;
    pend_m    = bus.m_axis_tvalid & bus.m_axis_tready;
    pend_data = bus.m_axis_tdata;
  endtask

  // Called at the falling edge: held bytes must not change, then record handshakes.
  task automatic sample();
    if (hold) begin
      check("stall_valid", 32'(bus.m_axis_tvalid), 1);
      check("stall_data", 32'(bus.m_axis_tdata), 32'(hold_data));
    end
    hold      = bus.m_axis_tvalid && !bus.m_axis_tready;
    hold_data = bus.m_axis_tdata;
    calc_hs();
  endtask

  task automatic cycle();
    @(posedge clk);
    if (pend_m) obs.push_back(pend_data);
    for (int i = 0; i < N; i++) begin
      if (pend_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    #1;
    cyc++;
    drive_src();
    drive_rdy();
    @(negedge clk);
    sample();
  endtask

  task automatic apply();
    drive_src();
    #1;
    calc_hs();
  endtask

  task automatic load(input int s, input logic [7:0] d, input logic l);
    src_q[s].push_back({d, l});
  endtask

  task automatic hdr(input int s);
    if (HDR_ON) exp_q.push_back(8'hA0 | 8'(s));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    obs.delete();
    exp_q.delete();
    pend_s = '0;
    pend_m = 1'b0;
    hold   = 1'b0;
    drive_src();
    repeat (2) cycle();
    rst_n = 1'b1;
    calc_hs();
  endtask

  function automatic bit pending_src();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((pending_src() || bus.m_axis_tvalid || busy) && n < 400) begin
      cycle();
      n++;
    end
    check({name, "_drain"}, 32'(n < 400), 1);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), 32'(obs[i]), 32'(exp_q[i]));
    obs.delete();
    exp_q.delete();
  endtask

  // Reference: grant the first non-empty source from the pointer, emit bytes until
  // tlast or MB bytes, then move the pointer past that source.
  task automatic model_run();
    beat_t mq[N][$];
    int    s;
    int    n;
    bit    done;
    beat_t b;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    forever begin
      s = -1;
      for (int k = 0; k < N; k++) begin
        if (s < 0 && mq[(m_ptr + k) % N].size() > 0) s = (m_ptr + k) % N;
      end
      if (s < 0) break;
      hdr(s);
      n = 0;
      done = 1'b0;
      while (!done) begin
        b = mq[s].pop_front();
        exp_q.push_back(b.data);
        n++;
        if (b.last || n == MB || mq[s].size() == 0) done = 1'b1;
      end
      m_ptr = (s + 1) % N;
    end
  endtask

  initial begin
    arb_vec_t tbl[6];
    int       n;
    int       s;
    int       npk;
    int       len;

    tbl[0] = '{mask: 4'b1111, n: 3'd4, ord: {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[1] = '{mask: 4'b1010, n: 3'd2, ord: {2'd0, 2'd0, 2'd3, 2'd1}};
    tbl[2] = '{mask: 4'b0100, n: 3'd1, ord: {2'd0, 2'd0, 2'd0, 2'd2}};
    tbl[3] = '{mask: 4'b1001, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd3}};
    tbl[4] = '{mask: 4'b0101, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd2}};
    tbl[5] = '{mask: 4'b0011, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd1}};

    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;

    // Reset values
    do_reset();
    check("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("rst_tdata", 32'(bus.m_axis_tdata), 0);
    check("rst_tready", 32'(bus.s_axis_tready), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);

    // Single source 1, latency and ordering
    load(1, 8'h11, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h33, 1'b1);
    apply();
    check("lat_t0_tvalid", 32'(bus.m_axis_tvalid), 0);
    cycle();
    check("lat_t1_grant", 32'(grant_id), 1);
    check("lat_t1_busy", 32'(busy), 1);
`ifdef UART_ARB_ID_HDR_EN
    check("lat_t1_tready", 32'(bus.s_axis_tready), 0);
    cycle();
    check("lat_t2_tvalid", 32'(bus.m_axis_tvalid), 1);
    check("lat_t2_hdr", 32'(bus.m_axis_tdata), 32'hA1);
    cycle();
    check("lat_t3_data", 32'(bus.m_axis_tdata), 32'h11);
`else
    check("lat_t1_tready", 32'(bus.s_axis_tready), 32'b0010);
    cycle();
    check("lat_t2_tvalid", 32'(bus.m_axis_tvalid), 1);
    check("lat_t2_data", 32'(bus.m_axis_tdata), 32'h11);
`endif
    hdr(1); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    drain("single");
    compare_stream("single");
    check("single_busy_end", 32'(busy), 0);
    check("single_grant_end", 32'(grant_id), 1);

    // Two sources from reset, then pointer wrap 3 -> 0
    do_reset();
    load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b1);
    load(2, 8'hC1, 1'b0); load(2, 8'hC2, 1'b1);
    apply();
    hdr(0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    hdr(2); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    drain("two_src");
    compare_stream("two_src");
    load(0, 8'hD0, 1'b1); load(1, 8'hD1, 1'b1);
    apply();
    hdr(0); exp_q.push_back(8'hD0); hdr(1); exp_q.push_back(8'hD1);
    drain("wrap");
    compare_stream("wrap");

    // Burst cut on source 3 (pointer now 2), source 0 served in between
    for (int i = 1; i <= 6; i++) load(3, 8'h30 + 8'(i), i == 6);
    load(0, 8'h01, 1'b0); load(0, 8'h02, 1'b1);
    apply();
    hdr(3); for (int i = 1; i <= 4; i++) exp_q.push_back(8'h30 + 8'(i));
    hdr(0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    hdr(3); exp_q.push_back(8'h35); exp_q.push_back(8'h36);
    drain("burst");
    compare_stream("burst");

    // Downstream backpressure 1,0,0,1 during a 5-byte packet
    tr_mode = 2;
    for (int i = 1; i <= 5; i++) load(2, 8'h50 + 8'(i), i == 5);
    apply();
    hdr(2); for (int i = 1; i <= 4; i++) exp_q.push_back(8'h50 + 8'(i));
    hdr(2); exp_q.push_back(8'h55);
    drain("stall");
    compare_stream("stall");
    tr_mode = 0;

    // Single-byte packet from source 2
    load(2, 8'h55, 1'b1);
    apply();
    hdr(2); exp_q.push_back(8'h55);
    drain("one_byte");
    compare_stream("one_byte");

    // arb_en low blocks new grants
    arb_en = 1'b0;
    load(0, 8'hE0, 1'b1);
    apply();
    repeat (5) cycle();
    check("arboff_busy", 32'(busy), 0);
    check("arboff_tready", 32'(bus.s_axis_tready), 0);
    check("arboff_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("arboff_obs", obs.size(), 0);
    arb_en = 1'b1;
    hdr(0); exp_q.push_back(8'hE0);
    drain("arbon");
    compare_stream("arbon");

    // arb_en falls during a grant: packet finishes, source 2 waits
    load(1, 8'hF1, 1'b0); load(1, 8'hF2, 1'b0); load(1, 8'hF3, 1'b1);
    load(2, 8'hF4, 1'b1);
    apply();
    n = 0;
    while (bus.s_axis_tready == '0 && n < 20) begin cycle(); n++; end
    check("arbfall_grant_seen", 32'(n < 20), 1);
    arb_en = 1'b0;
    repeat (12) cycle();
    hdr(1); exp_q.push_back(8'hF1); exp_q.push_back(8'hF2); exp_q.push_back(8'hF3);
    compare_stream("arbfall");
    check("arbfall_busy", 32'(busy), 0);
    check("arbfall_src2_waiting", src_q[2].size(), 1);
    arb_en = 1'b1;
    hdr(2); exp_q.push_back(8'hF4);
    drain("arbfall_resume");
    compare_stream("arbfall_resume");

    // Reset mid-packet; pointer returns to 0
    load(1, 8'h60, 1'b1);
    apply();
    hdr(1); exp_q.push_back(8'h60);
    drain("pre_rst");
    compare_stream("pre_rst");
    for (int i = 1; i <= 4; i++) load(1, 8'h70 + 8'(i), i == 4);
    apply();
    n = 0;
    while (obs.size() < (HDR_ON ? 3 : 2) && n < 20) begin cycle(); n++; end
    check("midrst_progress", 32'(n < 20), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("midrst_tdata", 32'(bus.m_axis_tdata), 0);
    check("midrst_tready", 32'(bus.s_axis_tready), 0);
    check("midrst_grant", 32'(grant_id), 0);
    check("midrst_busy", 32'(busy), 0);
    do_reset();
    load(1, 8'hE1, 1'b1); load(3, 8'hE3, 1'b1);
    apply();
    hdr(1); exp_q.push_back(8'hE1); hdr(3); exp_q.push_back(8'hE3);
    drain("post_rst");
    compare_stream("post_rst");

    // Arbitration order table (pointer carries across rows, starts at 0)
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) if (tbl[r].mask[i]) load(i, 8'h30 + 8'(i), 1'b1);
      apply();
      for (int k = 0; k < int'(tbl[r].n); k++) begin
        s = int'(tbl[r].ord[2*k +: 2]);
        hdr(s);
        exp_q.push_back(8'h30 + 8'(s));
      end
      drain($sformatf("tbl%0d", r));
      compare_stream($sformatf("tbl%0d", r));
    end

    // Randomized traffic against the stream model
    do_reset();
    m_ptr = 0;
    tr_mode = 1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        npk = int'($urandom_range(0, 2));
        for (int p = 0; p < npk; p++) begin
          len = int'($urandom_range(1, 7));
          for (int b = 0; b < len; b++) load(i, 8'($urandom), b == len - 1);
        end
      end
      model_run();
      apply();
      drain($sformatf("rnd%0d", r));
      compare_stream($sformatf("rnd%0d", r));
    end
    tr_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
